// File: rtl/counter_arbiter.sv
// Round-robin arbiter sharing one loadable up/down counter between two requesters.
// Programs Load/mode/data_in for the winner and reports terminal count (done) or watchdog timeout (err).
module counter_arbiter #(
  parameter int WIDTH    = 4,
  parameter int WD_LIMIT = 2**WIDTH + 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] req0_val,
  input  logic             req0_mode,
  input  logic [WIDTH-1:0] req1_val,
  input  logic             req1_mode,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [1:0]       err,
  output logic             busy,
  output logic             Load,
  output logic             mode,
  output logic [WIDTH-1:0] data_in,
  input  logic             RCO,
  input  logic [WIDTH-1:0] data_out
);

  localparam int WD_W = $clog2(WD_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state, state_nx;
  logic             owner, owner_nx;
  logic             ptr, ptr_nx;
  logic             winner;
  logic [WD_W-1:0]  wd, wd_nx;
  logic             mode_nx;
  logic [WIDTH-1:0] data_in_nx;
  logic [1:0]       owner_oh;

  // The counter value is only observed externally; control relies on RCO alone.
  logic unused_data_out;
  assign unused_data_out = ^data_out;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      owner   <= 1'b0;
      ptr     <= 1'b0;
      wd      <= '0;
      mode    <= 1'b0;
      data_in <= '0;
    end else begin
      state   <= state_nx;
      owner   <= owner_nx;
      ptr     <= ptr_nx;
      wd      <= wd_nx;
      mode    <= mode_nx;
      data_in <= data_in_nx;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nx   = state;
    owner_nx   = owner;
    ptr_nx     = ptr;
    wd_nx      = wd;
    mode_nx    = mode;
    data_in_nx = data_in;
    winner     = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (req != 2'b00) begin
          // ptr names the requester favoured when both are asking.
          winner     = (req == 2'b11) ? ptr : req[1];
          owner_nx   = winner;
          ptr_nx     = ~winner;
          data_in_nx = winner ? req1_val : req0_val;
          mode_nx    = winner ? req1_mode : req0_mode;
          state_nx   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!req[owner]) begin
          state_nx = S_IDLE;
        end else begin
          state_nx = S_RUN;
          wd_nx    = '0;
        end
      end
      S_RUN: begin
        if (!req[owner]) begin
          state_nx = S_IDLE;
        end else if (RCO) begin
          state_nx = S_DONE;
        end else if (wd == WD_W'(WD_LIMIT - 1)) begin
          state_nx = S_ERR;
        end else begin
          wd_nx = wd + WD_W'(1);
        end
      end
      S_DONE:  state_nx = S_IDLE;
      S_ERR:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign owner_oh = owner ? 2'b10 : 2'b01;
  assign busy     = (state != S_IDLE);
  assign Load     = (state == S_LOAD);
  assign gnt      = busy ? owner_oh : 2'b00;
  assign done     = (state == S_DONE) ? owner_oh : 2'b00;
  assign err      = (state == S_ERR) ? owner_oh : 2'b00;

endmodule

// File: tb/tb_counter_arbiter.sv
// Self-checking bench for counter_arbiter: directed job table, multi-cycle corner
// sequences, and randomized traffic against a job-level reference model.
module tb_counter_arbiter;

  localparam int WIDTH    = 4;
  localparam int WD_LIMIT = 2**WIDTH + 2;
  localparam int MAXV     = 2**WIDTH - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       req = 2'b00;
  logic [WIDTH-1:0] req0_val = '0;
  logic             req0_mode = 1'b0;
  logic [WIDTH-1:0] req1_val = '0;
  logic             req1_mode = 1'b0;
  logic [1:0]       gnt, done, err;
  logic             busy, Load, mode;
  logic [WIDTH-1:0] data_in;
  logic             RCO;
  logic [WIDTH-1:0] cnt = '0;
  logic             force_low = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  counter_arbiter #(.WIDTH(WIDTH), .WD_LIMIT(WD_LIMIT)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req0_val (req0_val),
    .req0_mode(req0_mode),
    .req1_val (req1_val),
    .req1_mode(req1_mode),
    .gnt      (gnt),
    .done     (done),
    .err      (err),
    .busy     (busy),
    .Load     (Load),
    .mode     (mode),
    .data_in  (data_in),
    .RCO      (RCO),
    .data_out (cnt)
  );

  initial forever #5 clk = ~clk;

  // Behavioural model of the shared counter; force_low emulates a stuck RCO.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (Load)      cnt <= data_in;
    else if (mode) cnt <= cnt + 1'b1;
    else           cnt <= cnt - 1'b1;
  end
  assign RCO = !force_low && (mode ? (cnt == '1) : (cnt == '0));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  function automatic logic [31:0] dut_outputs();
    return {19'd0, gnt, done, err, busy, Load, mode, data_in};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits up to max_cyc cycles for a done/err pulse; returns the pulse bits or 0.
  task automatic wait_pulse(input int max_cyc, output logic [1:0] bits);
    bits = 2'b00;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (done != 2'b00 || err != 2'b00) begin
        bits = done | err;
        break;
      end
    end
  endtask

  // ---------------- directed job table ----------------
  typedef struct {
    logic [1:0]       req;
    logic [WIDTH-1:0] v0;
    logic             m0;
    logic [WIDTH-1:0] v1;
    logic             m1;
    logic             stuck;
    logic [1:0]       exp_bits;
    int               exp_cyc;
    logic             exp_err;
  } vec_t;

  task automatic run_job(input vec_t v, input int idx);
    int               t0, hit_cyc, load_cyc, gnt_cycles;
    logic [1:0]       hit_bits, hit_kind;
    logic [WIDTH-1:0] load_data;
    do_reset();
    force_low = v.stuck;
    req0_val  = v.v0;
    req0_mode = v.m0;
    req1_val  = v.v1;
    req1_mode = v.m1;
    req       = v.req;
    t0 = cyc; hit_cyc = -1; load_cyc = -1; gnt_cycles = 0;
    hit_bits = 2'b00; hit_kind = 2'b00; load_data = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (Load && load_cyc < 0) begin
        load_cyc  = cyc - t0;
        load_data = data_in;
      end
      if (gnt == v.exp_bits) gnt_cycles++;
      if (done != 2'b00 || err != 2'b00) begin
        hit_cyc  = cyc - t0;
        hit_bits = done | err;
        hit_kind = {done != 2'b00, err != 2'b00};
        req      = 2'b00;
        break;
      end
    end
    check($sformatf("job%0d_cycle", idx), hit_cyc, v.exp_cyc);
    check($sformatf("job%0d_owner", idx), hit_bits, v.exp_bits);
    check($sformatf("job%0d_kind", idx), hit_kind, v.exp_err ? 2'b01 : 2'b10);
    check($sformatf("job%0d_load_cycle", idx), load_cyc, 1);
    check($sformatf("job%0d_load_data", idx), load_data, v.exp_bits[1] ? v.v1 : v.v0);
    check($sformatf("job%0d_gnt_cycles", idx), gnt_cycles, v.exp_cyc);
    force_low = 1'b0;
  endtask

  // ---------------- job-level reference model ----------------
  bit               m_busy, m_owner, m_ptr, m_mode;
  logic [WIDTH-1:0] m_data;
  int               m_off, m_end;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_mode = 0; m_data = '0;
    m_off = 0; m_end = 0;
  endtask

  // Advances the model by one clock using the inputs applied for this cycle.
  // A job granted in cycle t0 shows Load at t0+1 and finishes at t0+3+steps.
  task automatic model_step();
    bit               w, md;
    logic [WIDTH-1:0] v;
    int               steps;
    if (!m_busy) begin
      if (req != 2'b00) begin
        w       = (req == 2'b11) ? m_ptr : req[1];
        m_ptr   = !w;
        m_owner = w;
        v       = w ? req1_val : req0_val;
        md      = w ? req1_mode : req0_mode;
        m_data  = v;
        m_mode  = md;
        steps   = md ? (MAXV - int'(v)) : int'(v);
        m_busy  = 1;
        m_off   = 1;
        m_end   = 3 + steps;
      end
    end else if (m_off == m_end) begin
      m_busy = 0;
    end else if (!req[m_owner]) begin
      m_busy = 0;
    end else begin
      m_off++;
    end
  endtask

  function automatic logic [31:0] model_outputs();
    logic [1:0] oh = m_owner ? 2'b10 : 2'b01;
    return {19'd0, m_busy ? oh : 2'b00, (m_busy && m_off == m_end) ? oh : 2'b00, 2'b00,
            m_busy, m_busy && m_off == 1, m_mode, m_data};
  endfunction

  initial begin
    vec_t       tbl[10];
    logic [1:0] bits;
    logic [1:0] order[4];
    int         n_seen, overlap, stray;

    tbl[0] = '{2'b01, 4'd5,  1'b0, 4'd0,  1'b0, 1'b0, 2'b01, 8,  1'b0};
    tbl[1] = '{2'b10, 4'd0,  1'b0, 4'd15, 1'b1, 1'b0, 2'b10, 3,  1'b0};
    tbl[2] = '{2'b10, 4'd0,  1'b0, 4'd0,  1'b1, 1'b0, 2'b10, 18, 1'b0};
    tbl[3] = '{2'b01, 4'd0,  1'b0, 4'd0,  1'b0, 1'b0, 2'b01, 3,  1'b0};
    tbl[4] = '{2'b01, 4'd15, 1'b1, 4'd0,  1'b0, 1'b0, 2'b01, 3,  1'b0};
    tbl[5] = '{2'b01, 4'd15, 1'b0, 4'd0,  1'b0, 1'b0, 2'b01, 18, 1'b0};
    tbl[6] = '{2'b10, 4'd0,  1'b0, 4'd9,  1'b0, 1'b0, 2'b10, 12, 1'b0};
    tbl[7] = '{2'b11, 4'd3,  1'b0, 4'd7,  1'b1, 1'b0, 2'b01, 6,  1'b0};
    tbl[8] = '{2'b01, 4'd5,  1'b0, 4'd0,  1'b0, 1'b1, 2'b01, 2 + WD_LIMIT, 1'b1};
    tbl[9] = '{2'b10, 4'd0,  1'b0, 4'd4,  1'b1, 1'b1, 2'b10, 2 + WD_LIMIT, 1'b1};

    // Reset then idle: everything quiet for five cycles.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("idle_outputs", dut_outputs(), 32'd0);
    end

    for (int i = 0; i < 10; i++) run_job(tbl[i], i);

    // Both held back-to-back: service alternates 0,1,0,1 with no overlap.
    do_reset();
    req0_val = 4'd2; req0_mode = 1'b0;
    req1_val = 4'd2; req1_mode = 1'b0;
    req = 2'b11;
    n_seen = 0; overlap = 0;
    for (int k = 0; k < 4; k++) order[k] = 2'b00;
    for (int k = 0; k < 60 && n_seen < 4; k++) begin
      @(negedge clk);
      if ($countones(gnt) > 1 || $countones(done) > 1 || (done != 2'b00 && err != 2'b00)) overlap++;
      if (done != 2'b00) begin
        order[n_seen] = done;
        n_seen++;
      end
    end
    req = 2'b00;
    for (int k = 0; k < 4; k++) check($sformatf("rr_order%0d", k), order[k], (k % 2 == 0) ? 2'b01 : 2'b10);
    check("rr_overlap", overlap, 0);

    // Abort: drop req0 in RUN at cycle 4, idle at cycle 5, pointer already moved on.
    do_reset();
    req0_val = 4'd10; req0_mode = 1'b0;
    req = 2'b01;
    repeat (4) @(negedge clk);
    check("abort_busy_in_run", busy, 1'b1);
    req = 2'b00;
    @(negedge clk);
    check("abort_idle_next", {busy, gnt}, 3'b000);
    stray = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done != 2'b00 || err != 2'b00) stray++;
    end
    check("abort_no_pulse", stray, 0);
    req0_val = 4'd1; req1_val = 4'd1; req1_mode = 1'b0;
    req = 2'b11;
    wait_pulse(20, bits);
    req = 2'b00;
    check("abort_ptr_advanced", bits, 2'b10);

    // Reset mid-run: outputs clear next edge and requester 0 is favoured again.
    do_reset();
    req1_val = 4'd10; req1_mode = 1'b1;
    req = 2'b10;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrun_reset_outputs", dut_outputs(), 32'd0);
    reset = 1'b0;
    req0_val = 4'd1; req0_mode = 1'b0;
    req1_val = 4'd1; req1_mode = 1'b0;
    req = 2'b11;
    wait_pulse(20, bits);
    req = 2'b00;
    check("midrun_reset_ptr", bits, 2'b01);

    // Randomized traffic with occasional aborts, checked every cycle.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      check($sformatf("random_c%0d", c), dut_outputs(), model_outputs());
      for (int i = 0; i < 2; i++) begin
        if (!req[i]) begin
          if ($urandom_range(2) == 0) begin
            req[i] = 1'b1;
            if (i == 0) begin
              req0_val  = WIDTH'($urandom);
              req0_mode = 1'($urandom);
            end else begin
              req1_val  = WIDTH'($urandom);
              req1_mode = 1'($urandom);
            end
          end
        end else if (m_busy && int'(m_owner) == i) begin
          if (done[i]) req[i] = 1'b0;
          else if ($urandom_range(39) == 0) req[i] = 1'b0;
        end
      end
      model_step();
      @(negedge clk);
    end
    req = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1);
  end

endmodule

// File: doc/counter_arbiter.md
Name: counter_arbiter

Overview:
- Shares one loadable 4-bit up/down counter between two requesters that each need a timed count sequence.
- Arbitrates round-robin and programs the counter's Load/mode/data_in for the winner.
- Watches RCO for terminal count and returns a one-cycle done pulse, or an error pulse on watchdog timeout.
- Sits between requester logic and the counter instance: counter outputs feed this block; its control outputs feed the counter.

Parameters:
- WIDTH, 4, counter data width (data_in/data_out/req values).
- WD_LIMIT, 2**WIDTH+2, maximum RUN cycles without RCO before an error is declared.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  2  level request per requester; bit i held high until done[i]/err[i] or abort.
- req0_val  input  WIDTH  start value for requester 0.
- req0_mode  input  1  count direction for requester 0 (1 = up, 0 = down).
- req1_val  input  WIDTH  start value for requester 1.
- req1_mode  input  1  count direction for requester 1.
- gnt  output  2  one-hot grant, high from LOAD through DONE/ERR of the owner.
- done  output  2  one-cycle pulse: owner's count reached terminal.
- err  output  2  one-cycle pulse: watchdog expired for owner.
- busy  output  1  high in any state except IDLE.
- Load  output  1  counter synchronous load strobe.
- mode  output  1  counter direction, registered, held through RUN.
- data_in  output  WIDTH  counter load value, registered.
- RCO  input  1  counter ripple-carry; high when (mode=1, data_out=all-ones) or (mode=0, data_out=0).
- data_out  input  WIDTH  counter value; used only for debug/checking, not required for control.

Behaviour:
- Counter contract: Load has priority and loads data_in on the next edge; otherwise the counter steps every clock in the direction of mode.
- Reset (sync, high): state=IDLE; gnt=0, done=0, err=0, busy=0, Load=0, mode=0, data_in=0; RR pointer = requester 0 favoured. Reset in any state aborts the job at the next edge with no done/err.
- States: IDLE, LOAD, RUN, DONE, ERR.
- IDLE: if req!=0, pick the winner: if both are high, take the one not served last (pointer); if one is high, take it. Latch owner, data_in=val, mode=mode of owner; go to LOAD. Pointer updates on grant.
- LOAD (1 cycle): Load=1, gnt[owner]=1; go to RUN, clearing the watchdog counter.
- RUN: Load=0; mode/data_in held.
  - If RCO=1: go to DONE.
  - Else if watchdog == WD_LIMIT-1: go to ERR.
  - Else increment the watchdog.
- DONE: done[owner]=1 for exactly one cycle; go to IDLE.
- ERR: err[owner]=1 for exactly one cycle; go to IDLE.
- Abort: req[owner] low in LOAD or RUN → IDLE next edge, gnt drops, no done/err, pointer already advanced.
- Latency, down mode with start V: req sampled in IDLE at cycle 0 → Load=1 at cycle 1 → data_out=V at cycle 2 → RCO at cycle 2+V → done at cycle 3+V.
- Latency, up mode: done at cycle 3+(2**WIDTH-1-V).
- V=0 down or V=all-ones up: RCO immediately in RUN; done at cycle 3.
- done and err are never both high; at most one gnt bit is high at any time.
- Requester must drop req at or before the edge leaving DONE/ERR. A req still high in IDLE is treated as a new request subject to RR.
- RCO is ignored outside RUN. The counter free-runs in IDLE/DONE; this block does not care.

Test Plan:
- Reset then idle: all outputs 0, busy=0 for 5 cycles with req=00.
- Single down job: req=01, req0_val=5, req0_mode=0 → Load pulse at cycle 1 with data_in=5, gnt=01 cycles 1–8, done=01 at cycle 8, then IDLE.
- Up job boundary: req=10, req1_val=15, req1_mode=1 → done=10 at cycle 3. Repeat with req1_val=0 → done at cycle 18.
- Contention and round-robin:
  - req=11 from reset → requester 0 served first, then requester 1.
  - Next req=11 → requester 1 served first? No: the pointer alternates, so the order is 0,1,0,1 across back-to-back jobs with both held.
  - done pulses never overlap.
- Watchdog: counter model with RCO forced 0, req=01 → err=01 exactly WD_LIMIT cycles after RUN entry (18 for WIDTH=4), done never asserted.
- Abort and reset mid-run:
  - Drop req0 in RUN at cycle 4 → IDLE at cycle 5, no done/err.
  - Assert reset in RUN → all outputs 0 next edge, next job starts with requester 0 favoured.
